// File: rtl/k16_uart.sv
// K16 UART: 16-bit register interface, TX FIFO feeding a serial transmitter,
// and a single-byte receiver with valid/overrun/framing flags.
module k16_uart #(
  parameter int CLK_DIV    = 217,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] din,
  input  logic [2:0]  addr,
  input  logic        write_en,
  output logic [15:0] dout,
  output logic        tx,
  input  logic        rx,
  output logic        irq
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [15:0]   div_q, div_d;
  state_t        tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic          tx_q, tx_d;
  logic [7:0]    tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic [15:0]   tx_div_q, tx_div_d, tx_cnt_q, tx_cnt_d;
  logic [15:0]   rx_div_q, rx_div_d, rx_cnt_q, rx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic          rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d, rx_overrun_q, rx_overrun_d;
  logic          tx_dropped_q, tx_dropped_d, frame_err_q, frame_err_d;

  logic       wr_tx, tx_full, tx_empty, tx_busy, tx_pop, push;
  logic       rx_done_ok, rx_done_bad;
  logic [3:0] clr;

  assign wr_tx    = write_en && (addr == 3'd0);
  assign tx_full  = (fifo_cnt_q == CW'(FIFO_DEPTH));
  assign tx_empty = (fifo_cnt_q == '0);
  assign tx_busy  = (tx_state_q != S_IDLE);
  // A push into a full FIFO is still accepted when the transmitter frees a slot this cycle.
  assign push     = wr_tx && (!tx_full || tx_pop);
  assign clr      = (write_en && (addr == 3'd2)) ? din[6:3] : 4'b0000;
  assign tx       = tx_q;
  assign irq      = rx_valid_q | rx_overrun_q | frame_err_q;

  always_comb begin
    dout = 16'h0000;
    case (addr)
      3'd1:    dout = {8'h00, rx_byte_q};
      3'd2:    dout = {9'b0, frame_err_q, tx_dropped_q, rx_overrun_q, rx_valid_q,
                       tx_busy, tx_empty, tx_full};
      3'd3:    dout = div_q;
      default: dout = 16'h0000;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_d       = tx_q;
    tx_shift_d = tx_shift_q;
    tx_div_d   = tx_div_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = fifo_mem[rd_ptr_q];
          tx_div_d   = div_q;
          tx_cnt_d   = div_q - 16'd1;
          tx_d       = 1'b0;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == 16'd0) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = tx_div_q - 16'd1;
          tx_bit_d   = 3'd0;
          tx_d       = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = tx_div_q - 16'd1;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == 16'd0) begin
          // Chain straight into the next start bit so queued bytes leave no gap.
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = fifo_mem[rd_ptr_q];
            tx_div_d   = div_q;
            tx_cnt_d   = div_q - 16'd1;
            tx_d       = 1'b0;
            tx_state_d = S_START;
          end else begin
            tx_state_d = S_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = tx_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    case ({push, tx_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    div_d = div_q;
    if (write_en && (addr == 3'd3)) div_d = (din < 16'd4) ? 16'd4 : din;
  end

  always_comb begin
    rx_s1_d     = rx;
    rx_s2_d     = rx_s1_q;
    rx_prev_d   = rx_s2_q;
    rx_state_d  = rx_state_q;
    rx_shift_d  = rx_shift_q;
    rx_div_d    = rx_div_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_done_ok  = 1'b0;
    rx_done_bad = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = S_START;
          rx_div_d   = div_q;
          rx_cnt_d   = {1'b0, div_q[15:1]} - 16'd1;
        end
      end
      S_START: begin
        if (rx_cnt_q == 16'd0) begin
          rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
          rx_cnt_d   = rx_div_q - 16'd1;
          rx_bit_d   = 3'd0;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == 16'd0) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_cnt_d   = rx_div_q - 16'd1;
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == 16'd0) begin
          rx_state_d  = S_IDLE;
          rx_done_ok  = rx_s2_q;
          rx_done_bad = !rx_s2_q;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // Set beats clear; a valid cleared in the completion cycle does not count as an overrun.
  always_comb begin
    rx_byte_d    = rx_done_ok ? rx_shift_q : rx_byte_q;
    rx_valid_d   = rx_done_ok | (rx_valid_q & ~clr[0]);
    rx_overrun_d = (rx_done_ok & rx_valid_q & ~clr[0]) | (rx_overrun_q & ~clr[1]);
    tx_dropped_d = (wr_tx & tx_full & ~tx_pop) | (tx_dropped_q & ~clr[2]);
    frame_err_d  = rx_done_bad | (frame_err_q & ~clr[3]);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= din[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      div_q        <= 16'(CLK_DIV);
      tx_state_q   <= S_IDLE;
      tx_q         <= 1'b1;
      tx_shift_q   <= 8'h00;
      tx_div_q     <= 16'(CLK_DIV);
      tx_cnt_q     <= 16'd0;
      tx_bit_q     <= 3'd0;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= S_IDLE;
      rx_shift_q   <= 8'h00;
      rx_div_q     <= 16'(CLK_DIV);
      rx_cnt_q     <= 16'd0;
      rx_bit_q     <= 3'd0;
      rx_byte_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      tx_dropped_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      div_q        <= div_d;
      tx_state_q   <= tx_state_d;
      tx_q         <= tx_d;
      tx_shift_q   <= tx_shift_d;
      tx_div_q     <= tx_div_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      rx_s1_q      <= rx_s1_d;
      rx_s2_q      <= rx_s2_d;
      rx_prev_q    <= rx_prev_d;
      rx_state_q   <= rx_state_d;
      rx_shift_q   <= rx_shift_d;
      rx_div_q     <= rx_div_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_byte_q    <= rx_byte_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      tx_dropped_q <= tx_dropped_d;
      frame_err_q  <= frame_err_d;
    end
  end
endmodule

// File: tb/tb_k16_uart.sv
// Directed + randomized bench for k16_uart: TX waveform from a bit-time model,
// RX flags/data from a register-level model of the status rules.
module tb_k16_uart;
  localparam int TB_CLK_DIV = 217;
  localparam int LOGN       = 8192;

  logic        clk = 1'b0;
  logic        reset, write_en, rx, tx, irq;
  logic [15:0] din, dout;
  logic [2:0]  addr;

  int checks   = 0;
  int failures = 0;
  int unsigned cyc = 0;
  logic txlog [LOGN];
  logic [7:0] exp_bytes [8];

  // Reference model state
  logic [7:0] m_byte;
  logic m_valid, m_ovr, m_ferr, m_drop;

  k16_uart #(.CLK_DIV(TB_CLK_DIV), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .din(din), .addr(addr), .write_en(write_en),
    .dout(dout), .tx(tx), .rx(rx), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cyc < LOGN) txlog[cyc] = tx;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    write_en = 1'b0;
    addr = a;
    #1;
    d = dout;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    addr = a; din = d; write_en = 1'b1;
    @(negedge clk);
    write_en = 1'b0;
  endtask

  task automatic wait_until(input int unsigned target);
    while (cyc < target) @(negedge clk);
  endtask

  function automatic logic tx_exp(input logic [7:0] b, input int k, input int div);
    int idx;
    idx = k / div;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  function automatic logic [15:0] m_status();
    return {9'b0, m_ferr, m_drop, m_ovr, m_valid, 3'b010};
  endfunction

  task automatic check_stream(input string tag, input int unsigned start, input int div, input int n);
    int bad, first;
    bad = 0; first = -1;
    if (txlog[start-1] !== 1'b1) begin bad++; first = start - 1; end
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 10*div; k++) begin
        int unsigned p;
        p = start + i*10*div + k;
        if (p >= LOGN || txlog[p] !== tx_exp(exp_bytes[i], k, div)) begin
          if (first < 0) first = p;
          bad++;
        end
      end
    checks++;
    assert (bad == 0) else begin
      failures++;
      $error("FAIL %s observed=%0d_bad_cycles(first@%0d) expected=0_bad_cycles", tag, bad, first);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input int div, input logic stop_bit);
    rx = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (div) @(negedge clk);
    end
    rx = stop_bit;
    repeat (div) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic model_rx(input logic [7:0] b, input logic stop_bit);
    if (stop_bit) begin
      if (m_valid) m_ovr = 1'b1;
      m_byte = b; m_valid = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic model_clear(input logic [15:0] d);
    if (d[3]) m_valid = 1'b0;
    if (d[4]) m_ovr = 1'b0;
    if (d[5]) m_drop = 1'b0;
    if (d[6]) m_ferr = 1'b0;
  endtask

  task automatic check_rx_state(input string tag);
    logic [15:0] d;
    rd(3'd1, d); chk({tag, "_rxdata"}, d, {8'h00, m_byte});
    rd(3'd2, d); chk({tag, "_status"}, d, m_status());
    chk({tag, "_irq"}, {15'b0, irq}, {15'b0, m_valid | m_ovr | m_ferr});
  endtask

  initial begin
    logic [15:0] d;
    logic [7:0] b, b2;
    logic ok;
    int unsigned c, s;

    reset = 1'b1; write_en = 1'b0; addr = 3'd0; din = 16'h0; rx = 1'b1;
    m_byte = 8'h00; m_valid = 0; m_ovr = 0; m_ferr = 0; m_drop = 0;
    repeat (3) @(negedge clk);
    chk("reset_tx", {15'b0, tx}, 16'h0001);
    chk("reset_irq", {15'b0, irq}, 16'h0000);
    rd(3'd2, d); chk("reset_status", d, 16'h0002);
    rd(3'd3, d); chk("reset_divisor", d, 16'(TB_CLK_DIV));
    rd(3'd1, d); chk("reset_rxdata", d, 16'h0000);
    rd(3'd5, d); chk("reset_addr5", d, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single frame 8'hA5 at divisor 4
    wr(3'd3, 16'd4);
    rd(3'd3, d); chk("div4_readback", d, 16'd4);
    c = cyc;
    wr(3'd0, 16'h00A5);
    s = c + 2;
    wait_until(s + 39);
    rd(3'd2, d); chk("a5_busy_last_stop", d & 16'h0004, 16'h0004);
    @(negedge clk);
    rd(3'd2, d); chk("a5_idle_after_40", d, 16'h0002);
    exp_bytes[0] = 8'hA5;
    check_stream("a5_frame", s, 4, 1);

    // Five back-to-back writes, then a dropped sixth
    for (int i = 0; i < 6; i++) exp_bytes[i] = 8'($urandom_range(0, 255));
    c = cyc;
    for (int i = 0; i < 5; i++) begin
      addr = 3'd0; din = {8'h00, exp_bytes[i]}; write_en = 1'b1;
      @(negedge clk);
    end
    rd(3'd2, d); chk("burst_full_no_drop", d, 16'h0005);
    wr(3'd0, {8'h00, exp_bytes[5]});
    m_drop = 1'b1;
    rd(3'd2, d); chk("burst_dropped", d, 16'h0025);
    wait_until(c + 2 + 200 + 2);
    check_stream("burst_stream", c + 2, 4, 5);
    rd(3'd2, d); chk("burst_done_status", d, m_status());
    wr(3'd2, 16'h0020); model_clear(16'h0020);
    rd(3'd2, d); chk("drop_cleared", d, 16'h0002);

    // RX at divisor 8
    wr(3'd3, 16'd8);
    send_rx(8'h3C, 8, 1'b1); model_rx(8'h3C, 1'b1);
    check_rx_state("rx3c");
    wr(3'd2, 16'h0008); model_clear(16'h0008);
    check_rx_state("rx3c_clr");

    send_rx(8'h11, 8, 1'b1); model_rx(8'h11, 1'b1);
    send_rx(8'h22, 8, 1'b1); model_rx(8'h22, 1'b1);
    check_rx_state("overrun");
    b = 8'($urandom_range(0, 255));
    send_rx(b, 8, 1'b0); model_rx(b, 1'b0);
    check_rx_state("frame_err");
    wr(3'd2, 16'h0078); model_clear(16'h0078);
    check_rx_state("clear_all");

    // Clear of valid coinciding with a completed byte
    b = 8'($urandom_range(0, 255));
    send_rx(b, 8, 1'b1); model_rx(b, 1'b1);
    b2 = 8'($urandom_range(0, 255));
    fork
      send_rx(b2, 8, 1'b1);
      begin
        repeat (78) @(negedge clk);
        wr(3'd2, 16'h0018);
      end
    join
    m_byte = b2; m_valid = 1'b1; m_ovr = 1'b0;
    check_rx_state("clear_vs_set");

    // Short glitch must not disturb anything
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check_rx_state("glitch");

    // Randomized frames and clears against the model
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      send_rx(b, 8, ok); model_rx(b, ok);
      check_rx_state("rand_rx");
      d = 16'($urandom_range(0, 15)) << 3;
      wr(3'd2, d); model_clear(d);
      check_rx_state("rand_clr");
    end

    wr(3'd3, 16'd2);
    rd(3'd3, d); chk("div2_clamped", d, 16'd4);
    wr(3'd7, 16'hFFFF);
    rd(3'd3, d); chk("addr7_write_ignored", d, 16'd4);
    wr(3'd3, 16'd8);

    // Reset mid-frame for both directions
    b = 8'($urandom_range(0, 255));
    send_rx(b, 8, 1'b1); model_rx(b, 1'b1);
    wr(3'd0, 16'h00FF & 16'($urandom_range(0, 255)));
    rx = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1; rx = 1'b1;
    @(negedge clk);
    m_byte = 8'h00; m_valid = 0; m_ovr = 0; m_ferr = 0; m_drop = 0;
    chk("rst_mid_tx", {15'b0, tx}, 16'h0001);
    rd(3'd2, d); chk("rst_mid_status", d, 16'h0002);
    rd(3'd3, d); chk("rst_mid_divisor", d, 16'(TB_CLK_DIV));
    rd(3'd1, d); chk("rst_mid_rxdata", d, 16'h0000);
    chk("rst_mid_irq", {15'b0, irq}, 16'h0000);
    reset = 1'b0;
    c = cyc;
    repeat (100) @(negedge clk);
    begin
      int z;
      z = 0;
      for (int unsigned p = c; p < c + 100; p++) if (txlog[p] !== 1'b1) z++;
      chk("post_rst_tx_idle", 16'(z), 16'h0000);
    end
    check_rx_state("post_rst_nothing");
    wr(3'd3, 16'd8);
    b = 8'($urandom_range(0, 255));
    send_rx(b, 8, 1'b1); model_rx(b, 1'b1);
    check_rx_state("post_rst_fresh");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
